// File: rtl/serial_sub.sv
// Digit-serial subtractor: diff = a - b - bin, LSB digit first, DIGIT bits per cycle.
// Optional macro SERIAL_SUB_SAT_EN: unsigned saturate-at-zero on final borrow.
module serial_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT:0]   w_dig;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_final;
    logic             w_last;
    logic             w_accept;

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;

    assign w_dig  = {1'b0, r_a_sh[DIGIT-1:0]} - {1'b0, r_b_sh[DIGIT-1:0]}
                  - (DIGIT + 1)'(r_borrow);
    // Concatenate-then-shift keeps the MSB-side insert legal even when DIGIT == WIDTH.
    assign w_res_next = WIDTH'({w_dig[DIGIT-1:0], r_res} >> DIGIT);
    assign w_last     = (r_cnt == CW'(N - 1));

`ifdef SERIAL_SUB_SAT_EN
    assign w_final = w_res_next & {WIDTH{~w_dig[DIGIT]}};
`else
    assign w_final = w_res_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_next = RUN;
            RUN:  if (w_last) w_state_next = DONE;
            DONE: if (out_ready) w_state_next = in_valid ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_a_sh   <= r_a_sh >> DIGIT;
            r_b_sh   <= r_b_sh >> DIGIT;
            r_borrow <= w_dig[DIGIT];
            r_res    <= w_res_next;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_diff <= w_final;
                r_bout <= w_dig[DIGIT];
            end
        end
    end

endmodule
